// File: rtl/melody_sequencer.sv
// Step sequencer: plays a 16-entry programmable melody into the tone generator control byte.
// Each step holds for its duration code, then an optional silent gap; stops at END or loops.
module melody_sequencer #(
    parameter int TICK_DIV  = 10000,
    parameter int DUR_UNIT  = 16,
    parameter int GAP_TICKS = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        start,
    input  logic        stop,
    input  logic        loop,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [11:0] wr_data,
    output logic [7:0]  tone_ctrl,
    output logic        busy,
    output logic        done,
    output logic [3:0]  step_idx
);

    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int NOTE_MAX = 15 * DUR_UNIT;
    localparam int TICK_MAX = (NOTE_MAX > GAP_TICKS) ? NOTE_MAX : GAP_TICKS;
    localparam int TW       = $clog2(TICK_MAX + 1);

    localparam logic [PW-1:0] PRE_LOAD = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NOTE = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [11:0]    mem_q [16];
    logic [11:0]    mem_d [16];
    logic [11:0]    step_q, step_d;
    logic [PW-1:0]  pre_q, pre_d;
    logic [TW-1:0]  tick_q, tick_d;
    logic [7:0]     tone_ctrl_q, tone_ctrl_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [3:0]     step_idx_q, step_idx_d;

    logic           load_en;
    logic [3:0]     load_idx;
    logic           advance;
    logic [3:0]     next_idx;
    logic [11:0]    word;

    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        step_d      = step_q;
        pre_d       = pre_q;
        tick_d      = tick_q;
        tone_ctrl_d = tone_ctrl_q;
        busy_d      = busy_q;
        done_d      = done_q;
        step_idx_d  = step_idx_q;
        load_en     = 1'b0;
        load_idx    = 4'd0;
        advance     = 1'b0;
        word        = 12'd0;
        next_idx    = step_idx_q + 4'd1;

        if (ena) begin
            done_d = 1'b0;
            if (wr_en) begin
                mem_d[wr_addr] = wr_data;
            end

            if (stop) begin
                state_d     = S_IDLE;
                tone_ctrl_d = 8'd0;
                busy_d      = 1'b0;
                step_idx_d  = 4'd0;
                pre_d       = '0;
                tick_d      = '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            if (mem_q[0][11:8] == 4'd0) begin
                                done_d = 1'b1;
                            end else begin
                                load_en  = 1'b1;
                                load_idx = 4'd0;
                            end
                        end
                    end
                    S_NOTE, S_GAP: begin
                        if (pre_q != '0) begin
                            pre_d = pre_q - 1'b1;
                        end else if (tick_q != '0) begin
                            pre_d  = PRE_LOAD;
                            tick_d = tick_q - 1'b1;
                        end else if (state_q == S_NOTE && GAP_TICKS > 0) begin
                            state_d     = S_GAP;
                            tone_ctrl_d = {2'b00, step_q[5:0]};
                            pre_d       = PRE_LOAD;
                            tick_d      = GAP_LOAD;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase

                // End of song is either the index wrap or an END word at the next slot.
                if (advance) begin
                    if (next_idx == 4'd0 || mem_q[next_idx][11:8] == 4'd0) begin
                        if (loop && mem_q[0][11:8] != 4'd0) begin
                            load_en  = 1'b1;
                            load_idx = 4'd0;
                        end else begin
                            state_d     = S_IDLE;
                            tone_ctrl_d = 8'd0;
                            busy_d      = 1'b0;
                            done_d      = 1'b1;
                            step_idx_d  = 4'd0;
                            pre_d       = '0;
                            tick_d      = '0;
                        end
                    end else begin
                        load_en  = 1'b1;
                        load_idx = next_idx;
                    end
                end

                // Loads read the pre-edge memory so a same-edge write is not seen.
                if (load_en) begin
                    word        = mem_q[load_idx];
                    step_d      = word;
                    step_idx_d  = load_idx;
                    state_d     = S_NOTE;
                    busy_d      = 1'b1;
                    tone_ctrl_d = {word[7], ~word[6], word[5:0]};
                    pre_d       = PRE_LOAD;
                    tick_d      = TW'(int'(word[11:8]) * DUR_UNIT - 1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= 12'd0;
            end
            state_q     <= S_IDLE;
            step_q      <= 12'd0;
            pre_q       <= '0;
            tick_q      <= '0;
            tone_ctrl_q <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            step_idx_q  <= 4'd0;
        end else begin
            mem_q       <= mem_d;
            state_q     <= state_d;
            step_q      <= step_d;
            pre_q       <= pre_d;
            tick_q      <= tick_d;
            tone_ctrl_q <= tone_ctrl_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            step_idx_q  <= step_idx_d;
        end
    end

    assign tone_ctrl = tone_ctrl_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign step_idx  = step_idx_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer: directed vector table, hand-written corner
// sequences, and random songs compared against a per-cycle trace built from the step list.
module tb_melody_sequencer;

    localparam int TD = 4;
    localparam int DU = 2;
    localparam int GT = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena, start, stop, loop, wr_en;
    logic [3:0]  wr_addr;
    logic [11:0] wr_data;
    logic [7:0]  tone_ctrl;
    logic        busy, done;
    logic [3:0]  step_idx;

    int n_assert = 0;
    int n_fail   = 0;

    melody_sequencer #(.TICK_DIV(TD), .DUR_UNIT(DU), .GAP_TICKS(GT)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .stop(stop), .loop(loop),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .tone_ctrl(tone_ctrl), .busy(busy), .done(done), .step_idx(step_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start, stop, lp, en;
        logic [7:0] tone;
        logic       busy, done;
        logic [3:0] idx;
        logic       ci;
        int         n;
    } vec_t;

    typedef struct {
        logic [7:0] tone;
        logic       busy, done;
        logic [3:0] idx;
        logic       ci;
    } exp_t;

    logic [11:0] mdl_mem [16];
    exp_t        exp_q [$];
    vec_t        vecs [17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] et, input logic eb, input logic ed,
                       input logic [3:0] ei, input logic ci);
        logic [13:0] got, want;
        got  = {tone_ctrl, busy, done, (ci ? step_idx : 4'h0)};
        want = {et, eb, ed, (ci ? ei : 4'h0)};
        n_assert++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s t=%0t: tone/busy/done/idx got %h/%b/%b/%h expected %h/%b/%b/%h",
                     nm, $time, tone_ctrl, busy, done, step_idx, et, eb, ed, ei);
        end
    endtask

    task automatic write_step(input logic [3:0] a, input logic [11:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
        mdl_mem[a] = d;
    endtask

    // Expected per-cycle output after each edge, starting with the start edge (loop=0).
    task automatic build_trace();
        logic [11:0] w;
        logic [7:0]  t;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            w = mdl_mem[i];
            if (w[11:8] == 4'd0) break;
            t = {w[7], ~w[6], w[5:0]};
            repeat (int'(w[11:8]) * DU * TD) exp_q.push_back('{t, 1'b1, 1'b0, 4'(i), 1'b1});
            repeat (GT * TD) exp_q.push_back('{{2'b00, w[5:0]}, 1'b1, 1'b0, 4'(i), 1'b1});
        end
        exp_q.push_back('{8'h00, 1'b0, 1'b1, 4'h0, 1'b0});
        exp_q.push_back('{8'h00, 1'b0, 1'b0, 4'h0, 1'b0});
    endtask

    task automatic run_song(input string nm, input logic do_wr, input int wr_at,
                            input logic [3:0] wa, input logic [11:0] wd);
        build_trace();
        loop  = 1'b0;
        start = 1'b1;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (do_wr && k == wr_at) begin
                wr_en = 1'b1; wr_addr = wa; wr_data = wd;
            end
            tick();
            wr_en = 1'b0;
            start = 1'b0;
            chk(nm, exp_q[k].tone, exp_q[k].busy, exp_q[k].done, exp_q[k].idx, exp_q[k].ci);
        end
        if (do_wr) mdl_mem[wa] = wd;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] w;
        int          n;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h40, 1'b1, 1'b0, 4'd0, 1'b1, 1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h40, 1'b1, 1'b0, 4'd0, 1'b1, 23};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 4'd0, 1'b1, 4};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h49, 1'b1, 1'b0, 4'd1, 1'b1, 16};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h09, 1'b1, 1'b0, 4'd1, 1'b1, 4};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0, 1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 2};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h40, 1'b1, 1'b0, 4'd0, 1'b1, 1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h40, 1'b1, 1'b0, 4'd0, 1'b1, 23};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 4'd0, 1'b1, 4};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h49, 1'b1, 1'b0, 4'd1, 1'b1, 16};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h09, 1'b1, 1'b0, 4'd1, 1'b1, 4};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h40, 1'b1, 1'b0, 4'd0, 1'b1, 5};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1, 1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1, 3};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1, 1};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1, 2};

        for (int i = 0; i < 16; i++) mdl_mem[i] = 12'h000;
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
        wr_en = 1'b0; wr_addr = 4'h0; wr_data = 12'h000;
        #12;
        rst_n = 1'b1;
        #1;
        chk("reset", 8'h00, 1'b0, 1'b0, 4'd0, 1'b1);
        tick();
        chk("idle", 8'h00, 1'b0, 1'b0, 4'd0, 1'b1);

        run_song("empty_start", 1'b0, -1, 4'h0, 12'h000);

        write_step(4'd0, 12'h300);
        write_step(4'd1, 12'h209);
        write_step(4'd2, 12'h000);
        for (int r = 0; r < 17; r++) begin
            start = vecs[r].start; stop = vecs[r].stop; loop = vecs[r].lp; ena = vecs[r].en;
            for (int c = 0; c < vecs[r].n; c++) begin
                tick();
                start = 1'b0;
                stop  = 1'b0;
                chk($sformatf("vec%0d", r), vecs[r].tone, vecs[r].busy, vecs[r].done,
                    vecs[r].idx, vecs[r].ci);
            end
        end
        loop = 1'b0;

        write_step(4'd0, 12'h1C4);
        write_step(4'd1, 12'h000);
        run_song("rest_trem", 1'b0, -1, 4'h0, 12'h000);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ena_note", 8'h84, 1'b1, 1'b0, 4'd0, 1'b1);
        repeat (2) begin tick(); chk("ena_note", 8'h84, 1'b1, 1'b0, 4'd0, 1'b1); end
        ena = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 12'h3FF;
        repeat (10) begin tick(); chk("ena_frozen", 8'h84, 1'b1, 1'b0, 4'd0, 1'b1); end
        wr_en = 1'b0;
        ena = 1'b1;
        repeat (5) begin tick(); chk("ena_note", 8'h84, 1'b1, 1'b0, 4'd0, 1'b1); end
        repeat (4) begin tick(); chk("ena_gap", 8'h04, 1'b1, 1'b0, 4'd0, 1'b1); end
        tick();
        chk("ena_done", 8'h00, 1'b0, 1'b1, 4'd0, 1'b0);
        tick();
        chk("ena_after", 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);

        for (int i = 0; i < 16; i++) write_step(4'(i), 12'h100 | 12'(i));
        run_song("walk16_wr", 1'b1, 38, 4'd3, 12'h13A);
        run_song("walk16_new", 1'b0, -1, 4'h0, 12'h000);

        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(0, 16);
            for (int i = 0; i < 16; i++) begin
                if (i < n) w = {4'($urandom_range(1, 2)), 8'($urandom)};
                else       w = {4'h0, 8'($urandom)};
                write_step(4'(i), w);
            end
            run_song($sformatf("rand%0d", r), 1'b0, -1, 4'h0, 12'h000);
        end

        write_step(4'd0, 12'h300);
        write_step(4'd1, 12'h000);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("pre_rst", 8'h40, 1'b1, 1'b0, 4'd0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", 8'h00, 1'b0, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 16; i++) mdl_mem[i] = 12'h000;
        #1;
        rst_n = 1'b1;
        tick();
        run_song("rst_clears_mem", 1'b0, -1, 4'h0, 12'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
